stimulus_rate_controller: RTL and testbench

Converts one raw environmental stimulus into the inc/dec/setval control pulses that drive a downstream mood/need saturating counter. The raw input is synchronised and debounced in prescaler ticks. While the stimulus is sustained, the block emits rate-limited increment pulses. While it is absent, it emits slower decay (decrement) pulses. One instance sits between each sensor input and its counter.

---
 rtl/mimosa_pkg.sv | 28 ++
 rtl/stimulus_rate_controller_if.sv | 25 ++
 rtl/tick_timer.sv | 44 ++++
 rtl/stimulus_rate_controller.sv | 159 +++++++++++++++
 tb/tb_stimulus_rate_controller.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mimosa_pkg.sv
// Shared definitions for the stimulus channels: FSM state encoding, default
// timing constants and a small state-decode helper.
package mimosa_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StQualify = ST_QUALIFY,
    StActive  = ST_ACTIVE,
    StRelease = ST_RELEASE
  } state_e;

  // Default timing, shared by every stimulus channel unless overridden.
  localparam int unsigned DefTimerW    = 8;
  localparam int unsigned DefDebTicks  = 4;
  localparam int unsigned DefIncPeriod = 8;
  localparam int unsigned DefDecPeriod = 16;

  // The stimulus counts as present while it is held or being released.
  function automatic logic is_active(input state_e st);
    return (st == StActive) || (st == StRelease);
  endfunction

endpackage

// File: rtl/stimulus_rate_controller_if.sv
// Control bundle between a stimulus source/prescaler and the rate controller.
//   tick     : single-cycle prescaler enable
//   stim_raw : raw stimulus level (asynchronous)
//   clear    : synchronous counter-reset request
//   inc/dec/setval : single-cycle pulses to the downstream counter
//   active   : stimulus qualified (ACTIVE or RELEASE)
interface stimulus_rate_controller_if;
  logic tick;
  logic stim_raw;
  logic clear;
  logic inc;
  logic dec;
  logic setval;
  logic active;

  modport master (
    output tick, stim_raw, clear,
    input  inc, dec, setval, active
  );

  modport slave (
    input  tick, stim_raw, clear,
    output inc, dec, setval, active
  );
endinterface

// File: rtl/tick_timer.sv
// Prescaled up-counter with terminal flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear to 0 (wins over everything)
//   en_i       : counter is in use this cycle
//   tick_i     : prescaler enable; count advances only when en_i && tick_i
//   term_o     : count == LIMIT-1 on an enabled tick; the count returns to 0
module tick_timer #(
  parameter int unsigned TIMER_W = 8,
  parameter int unsigned LIMIT   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic term_o
);

  localparam logic [TIMER_W-1:0] LastVal = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               adv;

  assign adv    = en_i && tick_i;
  assign term_o = adv && (count_q == LastVal);

  always_comb begin
    count_d = count_q;
    if (clr_i || term_o) begin
      count_d = '0;
    end else if (adv) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stimulus_rate_controller.sv
// Turns one raw environmental stimulus into inc/dec/setval pulses for a
// downstream saturating counter. The stimulus is synchronised, debounced in
// prescaler ticks, then produces rate-limited increments while sustained and
// slower decay pulses while absent.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tick/stim_raw/clear in, inc/dec/setval/active out (all
//                outputs registered)
module stimulus_rate_controller
  import mimosa_pkg::*;
#(
  parameter int unsigned TIMER_W    = DefTimerW,
  parameter int unsigned DEB_TICKS  = DefDebTicks,
  parameter int unsigned INC_PERIOD = DefIncPeriod,
  parameter int unsigned DEC_PERIOD = DefDecPeriod
) (
  input  logic                       clk,
  input  logic                       rst_n,
  stimulus_rate_controller_if.slave  bus
);

  // Two-flop synchroniser; sync_q[1] is the only stimulus view used below.
  logic [1:0] sync_q, sync_d;
  logic       stim_s;

  assign sync_d = {sync_q[0], bus.stim_raw};
  assign stim_s = sync_q[1];

  state_e state_q, state_d;

  logic q_en,   q_clr,   q_term;
  logic per_en, per_clr, per_term;
  logic dec_en, dec_clr, dec_term;

  logic inc_q, inc_d;
  logic dec_q, dec_d;
  logic setval_q, setval_d;
  logic active_q, active_d;

  // The debounce timer runs only while the stimulus disagrees with the
  // qualified level; per_cnt freezes outside ACTIVE so RELEASE keeps the phase.
  assign q_en   = ((state_q == StQualify) && stim_s) || ((state_q == StRelease) && !stim_s);
  assign per_en = (state_q == StActive);
  assign dec_en = (state_q == StIdle);

  tick_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (DEB_TICKS)
  ) u_q_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (q_clr),
    .en_i   (q_en),
    .tick_i (bus.tick),
    .term_o (q_term)
  );

  tick_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (INC_PERIOD)
  ) u_per_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (per_clr),
    .en_i   (per_en),
    .tick_i (bus.tick),
    .term_o (per_term)
  );

  tick_timer #(
    .TIMER_W (TIMER_W),
    .LIMIT   (DEC_PERIOD)
  ) u_dec_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (dec_clr),
    .en_i   (dec_en),
    .tick_i (bus.tick),
    .term_o (dec_term)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, decided on the old state's rules only.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (stim_s) state_d = StQualify;
        StQualify: begin
          if (!stim_s)     state_d = StIdle;
          else if (q_term) state_d = StActive;
        end
        StActive:  if (!stim_s) state_d = StRelease;
        StRelease: begin
          if (stim_s)      state_d = StActive;
          else if (q_term) state_d = StIdle;
        end
      endcase
    end
  end

  // Timer restarts on state entry (and on clear); a fresh timer only starts
  // counting on the tick after the transition.
  always_comb begin
    q_clr   = bus.clear ||
              ((state_d != state_q) && ((state_d == StQualify) || (state_d == StRelease)));
    per_clr = bus.clear || ((state_q == StQualify) && (state_d == StActive));
    dec_clr = bus.clear || ((state_d != state_q) && (state_d == StIdle));
  end

  // Output decode; clear masks any inc/dec due in the same cycle.
  always_comb begin
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    setval_d = 1'b0;
    active_d = is_active(state_d);
    if (bus.clear) begin
      setval_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle:    dec_d = dec_term;
        StQualify: inc_d = q_term;
        StActive:  inc_d = per_term;
        StRelease: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      setval_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      setval_q <= setval_d;
      active_q <= active_d;
    end
  end

  assign bus.inc    = inc_q;
  assign bus.dec    = dec_q;
  assign bus.setval = setval_q;
  assign bus.active = active_q;

endmodule

// File: tb/tb_stimulus_rate_controller.sv
// Self-checking bench for stimulus_rate_controller (DEB=4, INC=8, DEC=16).
// Expected pulses (kind + cycle) are queued as stimulus is driven; a negedge
// monitor pops and compares whenever a pulse is due or seen.
module tb_stimulus_rate_controller;

  localparam logic [2:0] KInc = 3'b001;
  localparam logic [2:0] KDec = 3'b010;
  localparam logic [2:0] KSet = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  stimulus_rate_controller_if bus_if ();

  stimulus_rate_controller #(
    .TIMER_W    (8),
    .DEB_TICKS  (4),
    .INC_PERIOD (8),
    .DEC_PERIOD (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  // One clock: inputs apply to the next posedge; returns at the following negedge.
  task automatic step(input logic t, input logic s, input logic c);
    bus_if.tick     = t;
    bus_if.stim_raw = s;
    bus_if.clear    = c;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus_if.tick     = 1'b0;
    bus_if.stim_raw = 1'b0;
    bus_if.clear    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Pulse monitor.
  initial begin
    exp_t       e;
    logic [2:0] obs;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        obs = {bus_if.setval, bus_if.dec, bus_if.inc};
        if (obs != 3'b000) begin
          if (sb_q.size() == 0) begin
            chk("extra_pulse", 32'(obs), 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("pulse_kind", 32'(obs), 32'(e.kind));
            chk("pulse_cycle", cyc, e.cyc);
          end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
          e = sb_q.pop_front();
          chk("pulse_missing", 32'(obs), 32'(e.kind));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c;
    logic s;
    logic tk;

    // Reset held with stimulus and tick asserted: outputs stay low.
    rst_n           = 1'b0;
    bus_if.tick     = 1'b1;
    bus_if.stim_raw = 1'b1;
    bus_if.clear    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inc",    32'(bus_if.inc),    32'd0);
    chk("rst_dec",    32'(bus_if.dec),    32'd0);
    chk("rst_setval", 32'(bus_if.setval), 32'd0);
    chk("rst_active", 32'(bus_if.active), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // Tick every clk, stimulus sustained, with clear on a due inc and a held clear.
    for (int p = 1; p <= 32; p++) begin
      c = (p == 15) || (p >= 25 && p <= 27);
      if (p == 7 || p == 20 || p == 32) expect_pulse(KInc, p);
      if (c) expect_pulse(KSet, p);
      step(1'b1, 1'b1, c);
      if (p == 6 || p == 15 || p == 16 || p == 25) chk("active_lo", 32'(bus_if.active), 32'd0);
      if (p == 7 || p == 20 || p == 32) chk("active_hi", 32'(bus_if.active), 32'd1);
    end

    // Asynchronous reset mid-ACTIVE while inc is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_inc",    32'(bus_if.inc),    32'd0);
    chk("midrst_dec",    32'(bus_if.dec),    32'd0);
    chk("midrst_setval", 32'(bus_if.setval), 32'd0);
    chk("midrst_active", 32'(bus_if.active), 32'd0);
    chk("sb_empty_a", sb_q.size(), 32'd0);

    // Decay: no stimulus, tick every clk.
    do_reset();
    for (int p = 1; p <= 50; p++) begin
      if (p % 16 == 0) expect_pulse(KDec, p);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("decay_active", 32'(bus_if.active), 32'd0);
    chk("sb_empty_b", sb_q.size(), 32'd0);

    // Glitch: 10 idle ticks, then stimulus for 3 qualify ticks only.
    do_reset();
    for (int p = 1; p <= 120; p++) begin
      tk = (p % 4 == 0);
      s  = (p >= 41 && p <= 52);
      if (p == 116) expect_pulse(KDec, p);
      step(tk, s, 1'b0);
      if (p == 50 || p == 56) chk("glitch_active", 32'(bus_if.active), 32'd0);
    end
    chk("sb_empty_d", sb_q.size(), 32'd0);

    // Qualify, periodic inc, short drop (held period), long drop (release).
    do_reset();
    for (int p = 1; p <= 176; p++) begin
      tk = (p % 4 == 0);
      s  = !((p >= 53 && p <= 60) || p >= 93);
      if (p == 16 || p == 48 || p == 88) expect_pulse(KInc, p);
      if (p == 172) expect_pulse(KDec, p);
      step(tk, s, 1'b0);
      if (p == 15 || p == 108) chk("hyst_active_lo", 32'(bus_if.active), 32'd0);
      if (p == 16 || p == 58 || p == 62 || p == 107) chk("hyst_active_hi", 32'(bus_if.active), 32'd1);
    end
    chk("sb_empty_e", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
